// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot / priority encoder with valid-ready handshakes on both sides.
// Optional saturating error counter enabled by defining ONEHOT_ERR_CNT_EN.
module onehot_encoder_pipe #(
    parameter  int N     = 8,
    parameter  int MODE  = 0,
    parameter  int CNT_W = 8,
    localparam int W     = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_code,
    output logic         out_err,
    output logic         out_valid,
    input  logic         out_ready
`ifdef ONEHOT_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
`endif
);

    if (N < 2 || N > 256 || CNT_W < 1) begin : g_bad_param
        $error("onehot_encoder_pipe: N must be 2..256 and CNT_W >= 1");
    end

    logic [W-1:0] r_code;
    logic         r_err;
    logic         r_valid;

    logic [W-1:0] w_low_idx;
    logic         w_zero;
    logic         w_multi;
    logic         w_err;
    logic [W-1:0] w_code;
    logic         w_accept;

    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                w_low_idx = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if more than one bit was set.
    assign w_zero   = (in_vec == '0);
    assign w_multi  = ((in_vec & (in_vec - {{(N-1){1'b0}}, 1'b1})) != '0);
    assign w_err    = w_zero || ((MODE == 0) && w_multi);
    assign w_code   = w_err ? '0 : w_low_idx;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_code  <= w_code;
            r_err   <= w_err;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_code  = r_code;
    assign out_err   = r_err;
    assign out_valid = r_valid;

`ifdef ONEHOT_ERR_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // A clear coinciding with an erroneous accept still counts that error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (err_clr) begin
            r_cnt <= (w_accept && w_err) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (w_accept && w_err && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign err_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: a MODE 0 and a MODE 1 instance (N=8) against a behavioural model.
// Counter checks are compiled in when ONEHOT_ERR_CNT_EN is defined.
module tb_onehot_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] iv0 = 8'h00, iv1 = 8'h00;
    logic       ival0 = 1'b0, ival1 = 1'b0;
    logic       ordy0 = 1'b1, ordy1 = 1'b1;
    logic       irdy0, irdy1;
    logic [2:0] code0, code1;
    logic       err0, err1, oval0, oval1;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic [1:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.N(8), .MODE(0), .CNT_W(2)) u_m0 (
        .clk(clk), .rst(rst), .in_vec(iv0), .in_valid(ival0), .in_ready(irdy0),
        .out_code(code0), .out_err(err0), .out_valid(oval0), .out_ready(ordy0)
`ifdef ONEHOT_ERR_CNT_EN
        , .err_cnt(cnt0), .err_clr(clr0)
`endif
    );

    onehot_encoder_pipe #(.N(8), .MODE(1), .CNT_W(2)) u_m1 (
        .clk(clk), .rst(rst), .in_vec(iv1), .in_valid(ival1), .in_ready(irdy1),
        .out_code(code1), .out_err(err1), .out_valid(oval1), .out_ready(ordy1)
`ifdef ONEHOT_ERR_CNT_EN
        , .err_cnt(cnt1), .err_clr(clr1)
`endif
    );

`ifndef ONEHOT_ERR_CNT_EN
    assign cnt0 = 2'd0;
    assign cnt1 = 2'd0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Encode from the rules: isolate the lowest set bit arithmetically, count bits for one-hot.
    function automatic void model_enc(input logic [7:0] v, input int mode, output int code, output bit err);
        int iv;
        iv = int'(v);
        if (iv == 0 || (mode == 0 && $countones(v) != 1)) begin
            code = 0;
            err  = 1'b1;
        end else begin
            code = $clog2(iv & -iv);
            err  = 1'b0;
        end
    endfunction

    // Model state per instance: [0] = MODE 0, [1] = MODE 1.
    bit ev[2];
    int ec[2];
    bit ee[2];
    int ecnt[2];
    bit just_rst;

    task automatic model_step(input int idx, input logic [7:0] v, input logic vld,
                              input logic ordy, input logic clr);
        int c;
        bit e;
        bit acc;
        acc = vld && (!ev[idx] || ordy);
        if (acc) model_enc(v, idx, c, e);
        else e = 1'b0;
        if (clr) ecnt[idx] = (acc && e) ? 1 : 0;
        else if (acc && e && ecnt[idx] < 3) ecnt[idx]++;
        if (acc) begin
            ev[idx] = 1'b1;
            ec[idx] = c;
            ee[idx] = e;
        end else if (ordy) begin
            ev[idx] = 1'b0;
        end
    endtask

    always begin
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                ev[k] = 1'b0; ec[k] = 0; ee[k] = 1'b0; ecnt[k] = 0;
            end
            just_rst = 1'b1;
        end else begin
            model_step(0, iv0, ival0, ordy0, clr0);
            model_step(1, iv1, ival1, ordy1, clr1);
            just_rst = 1'b0;
        end
        #1;
        check("m0_out_valid", int'(oval0), int'(ev[0]));
        check("m1_out_valid", int'(oval1), int'(ev[1]));
        check("m0_in_ready", int'(irdy0), int'(!ev[0] || ordy0));
        check("m1_in_ready", int'(irdy1), int'(!ev[1] || ordy1));
        if (ev[0] || just_rst) begin
            check("m0_out_code", int'(code0), ec[0]);
            check("m0_out_err", int'(err0), int'(ee[0]));
        end
        if (ev[1] || just_rst) begin
            check("m1_out_code", int'(code1), ec[1]);
            check("m1_out_err", int'(err1), int'(ee[1]));
        end
`ifdef ONEHOT_ERR_CNT_EN
        check("m0_err_cnt", int'(cnt0), ecnt[0]);
        check("m1_err_cnt", int'(cnt1), ecnt[1]);
`endif
    end

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] mix_vec [8] = '{8'h01, 8'h06, 8'h80, 8'hFF, 8'h00, 8'h40, 8'h24, 8'h02};
    logic       mix_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("lit_reset_valid", int'(oval0), 0);
        check("lit_reset_ready", int'(irdy0), 1);

        // Walking one through MODE 0: codes 0..7 back to back.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            iv0 = 8'h01 << k; ival0 = 1'b1; ordy0 = 1'b1;
            settle();
            check("lit_walk_code", int'(code0), k);
            check("lit_walk_valid", int'(oval0), 1);
        end
        @(negedge clk);
        iv0 = 8'h00; ival0 = 1'b1;
        settle();
        check("lit_zero_err", int'(err0), 1);
        check("lit_zero_code", int'(code0), 0);
        @(negedge clk);
        iv0 = 8'h05;
        settle();
        check("lit_multi_err", int'(err0), 1);
        check("lit_multi_code", int'(code0), 0);
        @(negedge clk);
        ival0 = 1'b0; iv0 = 'x;
`ifdef ONEHOT_ERR_CNT_EN
        settle();
        check("lit_cnt_two", int'(cnt0), 2);
`endif

        // MODE 1 priority encode.
        @(negedge clk);
        iv1 = 8'hA8; ival1 = 1'b1;
        settle();
        check("lit_prio_a8", int'(code1), 3);
        check("lit_prio_a8_err", int'(err1), 0);
        @(negedge clk);
        iv1 = 8'h00;
        settle();
        check("lit_prio_zero_err", int'(err1), 1);
        check("lit_prio_zero_code", int'(code1), 0);
        @(negedge clk);
        iv1 = 8'h80;
        settle();
        check("lit_prio_top", int'(code1), 7);
        @(negedge clk);
        iv1 = 8'hFF;
        settle();
        check("lit_prio_ff", int'(code1), 0);
        @(negedge clk);
        ival1 = 1'b0; iv1 = 'x;

        // Backpressure, then drain and accept in the same cycle.
        @(negedge clk);
        iv0 = 8'h10; ival0 = 1'b1; ordy0 = 1'b1;
        @(negedge clk);
        ordy0 = 1'b0; iv0 = 8'h40;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("lit_bp_ready", int'(irdy0), 0);
            check("lit_bp_code", int'(code0), 4);
            check("lit_bp_valid", int'(oval0), 1);
        end
        @(negedge clk);
        ordy0 = 1'b1;
        settle();
        check("lit_bp_next_code", int'(code0), 6);
        check("lit_bp_next_valid", int'(oval0), 1);
        @(negedge clk);
        ival0 = 1'b0; iv0 = 'x;
        settle();
        check("lit_drain_valid", int'(oval0), 0);

        // Reset while holding a result.
        @(negedge clk);
        iv0 = 8'h20; ival0 = 1'b1; ordy0 = 1'b0;
        @(negedge clk);
        ival0 = 1'b0; iv0 = 'x;
        settle();
        check("lit_hold_code", int'(code0), 5);
        @(negedge clk);
        rst = 1'b1;
        settle();
        check("lit_rst_valid", int'(oval0), 0);
        check("lit_rst_code", int'(code0), 0);
        check("lit_rst_err", int'(err0), 0);
        check("lit_rst_ready", int'(irdy0), 1);
`ifdef ONEHOT_ERR_CNT_EN
        check("lit_rst_cnt", int'(cnt0), 0);
`endif
        @(negedge clk);
        rst = 1'b0; ordy0 = 1'b1;

`ifdef ONEHOT_ERR_CNT_EN
        // Saturation of a 2-bit counter, then clear racing an error.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv0 = 8'h00; ival0 = 1'b1;
        end
        settle();
        check("lit_cnt_sat", int'(cnt0), 3);
        @(negedge clk);
        iv0 = 8'h03; clr0 = 1'b1;
        settle();
        check("lit_cnt_clr_err", int'(cnt0), 1);
        @(negedge clk);
        ival0 = 1'b0; iv0 = 'x;
        settle();
        check("lit_cnt_clr_only", int'(cnt0), 0);
        @(negedge clk);
        clr0 = 1'b0;
`endif

        // Mixed vectors with ready toggling on both instances.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            iv0 = mix_vec[k]; ival0 = 1'b1; ordy0 = mix_rdy[k];
            iv1 = mix_vec[7 - k]; ival1 = (k % 3 != 2); ordy1 = mix_rdy[7 - k];
        end
        @(negedge clk);
        ival0 = 1'b0; ival1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
- Parametrised, registered successor to the team's 8:3 one-hot encoder: N-bit one-hot or priority input to a $clog2(N)-bit index.
- Single output register stage with valid/ready handshakes on both sides.
- Explicit error flag replaces the old high-impedance "invalid" output; sits between request-vector producers (arbiters, decoders) and index consumers.

Parameters:
- N, 8, input vector width; legal range 2..256.
- W, $clog2(N), output code width; derived, never overridden.
- MODE, 0, 0 = strict one-hot; 1 = priority (lowest set bit wins).
- CNT_W, 8, error counter width; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_vec  in  N  request vector
- in_valid  in  1  in_vec is valid
- in_ready  out  1  block can accept in_vec this cycle
- out_code  out  W  encoded index
- out_err  out  1  input was invalid for MODE
- out_valid  out  1  out_code/out_err are valid
- out_ready  in  1  downstream accepts output
- err_cnt  out  CNT_W  saturating error count (only with ONEHOT_ERR_CNT_EN)
- err_clr  in  1  clears err_cnt (only with ONEHOT_ERR_CNT_EN)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst high at a clk edge): out_valid=0, out_code=0, out_err=0, err_cnt=0. Reset wins over every other event in that cycle. An in-flight output is discarded.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Accept: in_valid && in_ready at a clk edge.
  - On accept, the output register loads the encode of in_vec and out_valid is set to 1.
  - Latency is 1 cycle.
  - Full throughput (1 per cycle) while out_ready stays high.
- Drain: out_valid && out_ready with no accept in the same cycle clears out_valid.
- Hold: while out_valid && !out_ready, out_code, out_err and out_valid stay stable.
- Encode, MODE 0 (strict one-hot):
  - Exactly one bit k set: out_code=k, out_err=0.
  - Zero bits set, or more than one set: out_code=0, out_err=1.
- Encode, MODE 1 (priority):
  - out_code = index of the lowest set bit, out_err=0.
  - in_vec==0: out_code=0, out_err=1.
- Width rule: when N is not a power of two, out_code never exceeds N-1.
- No internal state beyond the single output register (plus the counter). No FSM beyond the valid bit: EMPTY(out_valid=0) and FULL(out_valid=1).
  - EMPTY to FULL on accept.
  - FULL stays FULL on a simultaneous accept plus drain, or on hold.
  - FULL to EMPTY on drain without accept.
- in_vec is ignored when in_valid=0. The bench may drive X there.

Optional Feature:
- Macro: ONEHOT_ERR_CNT_EN.
- Defined: the err_cnt and err_clr ports exist.
  - err_cnt increments by 1 on each accepted transfer whose encode gives out_err=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - err_clr high zeroes err_cnt.
  - err_clr together with an erroneous accept in the same cycle gives err_cnt=1: the clear applies first, then the new error is counted.
- Undefined: neither port exists and no counter logic is present. Handshake and encode behaviour are identical in both builds.

Test Plan (N=8):
- MODE 0, out_ready=1, in_vec=8'h01,8'h02,...,8'h80 on consecutive cycles -> out_code 0..7 one cycle later, out_err=0, out_valid high for 8 consecutive cycles.
- MODE 0, in_vec=8'h00 then 8'h05 -> out_code=0 with out_err=1 for both. With ONEHOT_ERR_CNT_EN, err_cnt=2.
- MODE 1, in_vec=8'hA8 -> out_code=3, out_err=0; in_vec=8'h00 -> out_code=0, out_err=1.
- Backpressure: accept 8'h10, hold out_ready=0 for 3 cycles -> in_ready=0, out_code=4 stable. Then out_ready=1 with in_valid=1, in_vec=8'h40 -> drain and accept in the same cycle, next out_code=6.
- Reset mid-operation: out_valid=1 holding 8'h20, rst pulsed 1 cycle -> out_valid=0, out_code=0, out_err=0, err_cnt=0, in_ready=1 on the next cycle.
- ONEHOT_ERR_CNT_EN, CNT_W=2: 5 erroneous accepts -> err_cnt saturates at 3. err_clr together with an erroneous accept -> err_cnt=1.
